branch_predictor: RTL and testbench

Dynamic branch predictor and mispredict controller for the 5-stage RV32I pipeline.
- IF stage: looks up a direct-mapped BTB with 2-bit saturating counters and steers next-PC.
- MEM stage: compares the resolved outcome (from the MEM-stage branch resolution logic) with the prediction carried down the pipe. Raises flush/redirect on mismatch and trains the tables.
- Replaces the always-flush-on-taken scheme.

---
 rtl/bp_pkg.sv | 40 ++++
 rtl/bp_table.sv | 71 +++++++
 rtl/branch_predictor.sv | 147 ++++++++++++++
 tb/tb_branch_predictor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor: opcode
// constants, the 2-bit saturating counter type and the BTB entry layout.
package bp_pkg;

  // RV32I control-flow opcodes (inst[6:0])
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // 2-bit saturating direction counter; bit 1 is the taken prediction
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_t;

  // One BTB entry. The tag field is right-aligned; the table keeps only
  // its low TAG_W bits and returns the upper bits as zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    cnt_t        cnt;
  } btb_entry_t;

  // Saturating step toward the resolved direction; ST and SNT hold.
  function automatic cnt_t sat_update(input cnt_t cnt, input logic taken);
    cnt_t res;
    case (cnt)
      SNT:     res = taken ? WNT : SNT;
      WNT:     res = taken ? WT  : SNT;
      WT:      res = taken ? ST  : WNT;
      ST:      res = taken ? ST  : WT;
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB storage: one write port, two asynchronous read ports
// (IF lookup and MEM training lookup). Valid and counter arrays take the
// asynchronous reset; tag and target arrays are plain storage that is only
// meaningful behind a set valid bit.
module bp_table
  import bp_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter int         TAG_W    = 8,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  btb_entry_t       wdata_i,
  input  logic [IDX_W-1:0] if_idx_i,
  output btb_entry_t       if_entry_o,
  input  logic [IDX_W-1:0] mem_idx_i,
  output btb_entry_t       mem_entry_o
);

  localparam int DEPTH = 2 ** IDX_W;

  logic             valid_q  [DEPTH];
  cnt_t             cnt_q    [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];

  // Upper tag bits of the write data are not stored
  logic unused_wtag;
  assign unused_wtag = ^wdata_i.tag;

  // Valid and counter state: cleared asynchronously, written on training
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= cnt_t'(CNT_INIT);
      end
    end else if (we_i) begin
      valid_q[waddr_i] <= wdata_i.valid;
      cnt_q[waddr_i]   <= wdata_i.cnt;
    end
  end

  // Tag and target payload: no reset needed, gated by valid on read
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[waddr_i]    <= wdata_i.tag[TAG_W-1:0];
      target_q[waddr_i] <= wdata_i.target;
    end
  end

  // IF read port: pre-update contents, no write bypass
  always_comb begin
    if_entry_o = '{valid:  valid_q[if_idx_i],
                   tag:    32'(tag_q[if_idx_i]),
                   target: target_q[if_idx_i],
                   cnt:    cnt_q[if_idx_i]};
  end

  // MEM read port used to build the training write
  always_comb begin
    mem_entry_o = '{valid:  valid_q[mem_idx_i],
                    tag:    32'(tag_q[mem_idx_i]),
                    target: target_q[mem_idx_i],
                    cnt:    cnt_q[mem_idx_i]};
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor and mispredict controller for the 5-stage RV32I
// pipeline. IF looks up the BTB and steers next-PC in the same cycle; MEM
// compares the resolved outcome with the prediction carried down the pipe,
// raises a combinational flush/redirect on mismatch and trains the table.
//
// MEM-stage qualifier: i_mem_valid=1 means the MEM bundle (i_pc_mem,
// i_inst_mem, i_actual_*, i_pred_*_mem) is a real, non-stalled instruction
// presented for exactly this cycle; it is consumed (compared, counted and
// trained) on the rising edge. With i_mem_valid=0 every MEM input is ignored.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter int         TAG_W    = 8,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_if,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_mem_valid,
  input  logic [31:0] i_pc_mem,
  input  logic [31:0] i_inst_mem,
  input  logic        i_actual_taken,
  input  logic [31:0] i_actual_target,
  input  logic        i_pred_taken_mem,
  input  logic [31:0] i_pred_target_mem,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_br_count,
  output logic [31:0] o_miss_count
);

  logic [IDX_W-1:0] if_idx, mem_idx;
  logic [TAG_W-1:0] if_tag, mem_tag;
  btb_entry_t       if_entry, mem_entry, wr_entry;
  logic             wr_en;
  logic             if_hit, mem_hit;
  logic [1:0]       if_cnt;
  logic             pred_taken;
  logic [6:0]       opcode;
  logic             is_branch, is_jal, is_jalr, is_ctrl;
  logic             mispredict;
  logic [31:0]      br_count_q, br_count_d;
  logic [31:0]      miss_count_q, miss_count_d;

  // PC bits outside index/tag and instruction bits above the opcode are
  // intentionally ignored
  logic unused_bits;
  assign unused_bits = ^{i_inst_mem[31:7], i_pc_if, i_pc_mem,
                         if_entry.tag, mem_entry.tag};

  assign if_idx  = i_pc_if[IDX_W+1:2];
  assign if_tag  = i_pc_if[IDX_W+TAG_W+1:IDX_W+2];
  assign mem_idx = i_pc_mem[IDX_W+1:2];
  assign mem_tag = i_pc_mem[IDX_W+TAG_W+1:IDX_W+2];

  bp_table #(
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W),
    .CNT_INIT(CNT_INIT)
  ) u_table (
    .clk_i      (i_clk),
    .rst_i      (i_reset),
    .we_i       (wr_en),
    .waddr_i    (mem_idx),
    .wdata_i    (wr_entry),
    .if_idx_i   (if_idx),
    .if_entry_o (if_entry),
    .mem_idx_i  (mem_idx),
    .mem_entry_o(mem_entry)
  );

  // IF lookup: hit on valid + tag match, predict taken on counter MSB
  always_comb begin
    if_cnt        = if_entry.cnt;
    if_hit        = if_entry.valid && (if_entry.tag[TAG_W-1:0] == if_tag);
    pred_taken    = !i_reset && if_hit && if_cnt[1];
    o_pred_taken  = pred_taken;
    o_pred_target = pred_taken ? if_entry.target : i_pc_if + 32'd4;
  end

  // MEM compare: direction mismatch, or taken with a wrong target. Applies
  // to every instruction so aliased non-control hits are flushed too.
  always_comb begin
    mispredict = i_mem_valid && !i_reset &&
                 ((i_actual_taken != i_pred_taken_mem) ||
                  (i_actual_taken && (i_pred_target_mem != i_actual_target)));
    o_mispredict  = mispredict;
    o_redirect_pc = i_actual_taken ? i_actual_target : i_pc_mem + 32'd4;
  end

  // Training decode: choose whether and what to write at the MEM index
  always_comb begin
    opcode    = i_inst_mem[6:0];
    is_branch = (opcode == OP_BRANCH);
    is_jal    = (opcode == OP_JAL);
    is_jalr   = (opcode == OP_JALR);
    is_ctrl   = is_branch || is_jal || is_jalr;
    mem_hit   = mem_entry.valid && (mem_entry.tag[TAG_W-1:0] == mem_tag);
    wr_en     = 1'b0;
    wr_entry  = mem_entry;
    if (i_mem_valid) begin
      if (is_branch) begin
        if (mem_hit) begin
          wr_en        = 1'b1;
          wr_entry.cnt = sat_update(mem_entry.cnt, i_actual_taken);
          if (i_actual_taken) wr_entry.target = i_actual_target;
        end else if (i_actual_taken) begin
          wr_en    = 1'b1;
          wr_entry = '{valid: 1'b1, tag: 32'(mem_tag),
                       target: i_actual_target, cnt: WT};
        end
      end else if (is_jal) begin
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: 32'(mem_tag),
                     target: i_actual_target, cnt: ST};
      end else if (mem_hit) begin
        // JALR or non-control instruction aliasing a live entry
        wr_en          = 1'b1;
        wr_entry.valid = 1'b0;
      end
    end
  end

  // Perf counter next-state, wrapping modulo 2^32
  always_comb begin
    br_count_d   = br_count_q + {31'd0, (i_mem_valid && is_ctrl)};
    miss_count_d = miss_count_q + {31'd0, mispredict};
  end

  // Perf counter registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      br_count_q   <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign o_br_count   = br_count_q;
  assign o_miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: table of cycle vectors with hand-derived
// expected outputs, routed through an expected-value queue, plus a
// hand-written mid-stream reset sequence.
module tb_branch_predictor;
  import bp_pkg::*;

  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_006f;
  localparam logic [31:0] JALR = 32'h0000_0067;
  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam int EXP_W = 131;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_pc_if;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_mem_valid;
  logic [31:0] i_pc_mem;
  logic [31:0] i_inst_mem;
  logic        i_actual_taken;
  logic [31:0] i_actual_target;
  logic        i_pred_taken_mem;
  logic [31:0] i_pred_target_mem;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc;
  logic [31:0] o_br_count;
  logic [31:0] o_miss_count;

  branch_predictor dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_pc_if          (i_pc_if),
    .o_pred_taken     (o_pred_taken),
    .o_pred_target    (o_pred_target),
    .i_mem_valid      (i_mem_valid),
    .i_pc_mem         (i_pc_mem),
    .i_inst_mem       (i_inst_mem),
    .i_actual_taken   (i_actual_taken),
    .i_actual_target  (i_actual_target),
    .i_pred_taken_mem (i_pred_taken_mem),
    .i_pred_target_mem(i_pred_target_mem),
    .o_mispredict     (o_mispredict),
    .o_redirect_pc    (o_redirect_pc),
    .o_br_count       (o_br_count),
    .o_miss_count     (o_miss_count)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [31:0] pc_if;
    bit          mv;
    logic [31:0] pc_mem;
    logic [31:0] inst;
    bit          at;
    logic [31:0] atgt;
    bit          pt;
    logic [31:0] ptgt;
    bit          e_pt;
    logic [31:0] e_ptgt;
    bit          e_mis;
    logic [31:0] e_rd;
    logic [31:0] e_br;
    logic [31:0] e_miss;
  } vec_t;

  vec_t             vecs[$];
  logic [EXP_W-1:0] exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;

  function automatic vec_t mk(input bit r, input logic [31:0] pcif, input bit mv,
                              input logic [31:0] pcm, input logic [31:0] inst,
                              input bit at, input logic [31:0] atgt,
                              input bit pt, input logic [31:0] ptgt,
                              input bit ept, input logic [31:0] eptgt,
                              input bit emis, input logic [31:0] erd,
                              input logic [31:0] ebr, input logic [31:0] emiss);
    vec_t v;
    v.rst = r; v.pc_if = pcif; v.mv = mv; v.pc_mem = pcm; v.inst = inst;
    v.at = at; v.atgt = atgt; v.pt = pt; v.ptgt = ptgt;
    v.e_pt = ept; v.e_ptgt = eptgt; v.e_mis = emis; v.e_rd = erd;
    v.e_br = ebr; v.e_miss = emiss;
    return v;
  endfunction

  task automatic check32(input string name, input int id,
                         input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, got, exp);
    end
  endtask

  task automatic do_reset();
    i_mem_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Driver: apply one vector and queue its expected outputs
  task automatic drive(input vec_t v);
    i_pc_if           = v.pc_if;
    i_mem_valid       = v.mv;
    i_pc_mem          = v.pc_mem;
    i_inst_mem        = v.inst;
    i_actual_taken    = v.at;
    i_actual_target   = v.atgt;
    i_pred_taken_mem  = v.pt;
    i_pred_target_mem = v.ptgt;
    exp_q.push_back({v.e_pt, v.e_ptgt, v.e_mis, v.e_mis, v.e_rd, v.e_br, v.e_miss});
  endtask

  // Scoreboard: pop the oldest expectation and compare the live outputs
  task automatic compare(input int id);
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard step %0d: got empty queue expected an entry", id);
      return;
    end
    e = exp_q.pop_front();
    check32("pred_taken", id, {31'd0, o_pred_taken}, {31'd0, e[130]});
    check32("pred_target", id, o_pred_target, e[129:98]);
    check32("mispredict", id, {31'd0, o_mispredict}, {31'd0, e[97]});
    if (e[96]) check32("redirect_pc", id, o_redirect_pc, e[95:64]);
    check32("br_count", id, o_br_count, e[63:32]);
    check32("miss_count", id, o_miss_count, e[31:0]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_pc_if = 32'h0; i_mem_valid = 1'b0; i_pc_mem = 32'h0; i_inst_mem = ADDI;
    i_actual_taken = 1'b0; i_actual_target = 32'h0;
    i_pred_taken_mem = 1'b0; i_pred_target_mem = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //             rst pc_if    mv pc_mem   inst  at atgt    pt ptgt    ept eptgt  mis redir   br miss
    vecs.push_back(mk(0, 32'h100, 0, 32'h500, BEQ,  1, 32'h44,  1, 32'h48,  0, 32'h104, 0, 32'h0,   0, 0));
    vecs.push_back(mk(0, 32'h200, 1, 32'h200, BEQ,  1, 32'h180, 0, 32'h204, 0, 32'h204, 1, 32'h180, 0, 0));
    vecs.push_back(mk(0, 32'h200, 0, 32'h0,   ADDI, 0, 32'h0,   0, 32'h0,   1, 32'h180, 0, 32'h0,   1, 1));
    vecs.push_back(mk(0, 32'h200, 1, 32'h200, BEQ,  1, 32'h180, 1, 32'h180, 1, 32'h180, 0, 32'h0,   1, 1));
    vecs.push_back(mk(0, 32'h200, 1, 32'h200, BEQ,  0, 32'h0,   1, 32'h180, 1, 32'h180, 1, 32'h204, 2, 1));
    vecs.push_back(mk(0, 32'h200, 1, 32'h200, BEQ,  0, 32'h0,   1, 32'h180, 1, 32'h180, 1, 32'h204, 3, 2));
    vecs.push_back(mk(0, 32'h200, 0, 32'h0,   ADDI, 0, 32'h0,   0, 32'h0,   0, 32'h204, 0, 32'h0,   4, 3));
    vecs.push_back(mk(0, 32'h200, 1, 32'h200, BEQ,  0, 32'h0,   0, 32'h204, 0, 32'h204, 0, 32'h0,   4, 3));
    vecs.push_back(mk(1, 32'h300, 1, 32'h300, JAL,  1, 32'h400, 0, 32'h304, 0, 32'h304, 1, 32'h400, 0, 0));
    vecs.push_back(mk(0, 32'h300, 1, 32'h300, JAL,  1, 32'h400, 1, 32'h400, 1, 32'h400, 0, 32'h0,   1, 1));
    vecs.push_back(mk(0, 32'h300, 0, 32'h0,   ADDI, 0, 32'h0,   0, 32'h0,   1, 32'h400, 0, 32'h0,   2, 1));
    vecs.push_back(mk(0, 32'h1300,1, 32'h1300,ADDI, 0, 32'h0,   0, 32'h1304,0, 32'h1304,0, 32'h0,   2, 1));
    vecs.push_back(mk(0, 32'h300, 0, 32'h0,   ADDI, 0, 32'h0,   0, 32'h0,   1, 32'h400, 0, 32'h0,   2, 1));
    vecs.push_back(mk(0, 32'h300, 1, 32'h300, ADDI, 0, 32'h0,   1, 32'h400, 1, 32'h400, 1, 32'h304, 2, 1));
    vecs.push_back(mk(0, 32'h300, 0, 32'h0,   ADDI, 0, 32'h0,   0, 32'h0,   0, 32'h304, 0, 32'h0,   2, 2));
    vecs.push_back(mk(0, 32'h304, 1, 32'h300, JAL,  1, 32'h500, 1, 32'h400, 0, 32'h308, 1, 32'h500, 2, 2));
    vecs.push_back(mk(0, 32'h300, 1, 32'h300, JALR, 1, 32'h600, 1, 32'h500, 1, 32'h500, 1, 32'h600, 3, 3));
    vecs.push_back(mk(0, 32'h300, 0, 32'h0,   ADDI, 0, 32'h0,   0, 32'h0,   0, 32'h304, 0, 32'h0,   4, 4));
    vecs.push_back(mk(0, 32'h300, 0, 32'h300, JAL,  1, 32'h700, 0, 32'h304, 0, 32'h304, 0, 32'h0,   4, 4));
    vecs.push_back(mk(0, 32'h300, 0, 32'h0,   ADDI, 0, 32'h0,   0, 32'h0,   0, 32'h304, 0, 32'h0,   4, 4));
    vecs.push_back(mk(0, 32'h400, 1, 32'h400, BEQ,  0, 32'h0,   0, 32'h404, 0, 32'h404, 0, 32'h0,   4, 4));
    vecs.push_back(mk(0, 32'h400, 0, 32'h0,   ADDI, 0, 32'h0,   0, 32'h0,   0, 32'h404, 0, 32'h0,   5, 4));
    vecs.push_back(mk(0, 32'h4c,  1, 32'h4c,  BEQ,  1, 32'h10,  0, 32'h50,  0, 32'h50,  1, 32'h10,  5, 4));
    vecs.push_back(mk(0, 32'h4c,  0, 32'h0,   ADDI, 0, 32'h0,   0, 32'h0,   1, 32'h10,  0, 32'h0,   6, 5));
    vecs.push_back(mk(0, 32'h4c,  1, 32'h4c,  BEQ,  1, 32'h20,  1, 32'h10,  1, 32'h10,  1, 32'h20,  6, 5));
    vecs.push_back(mk(0, 32'h4c,  0, 32'h0,   ADDI, 0, 32'h0,   0, 32'h0,   1, 32'h20,  0, 32'h0,   7, 6));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i]);
      @(negedge clk);
      compare(i);
      @(posedge clk);
      #1;
    end

    // Mid-stream reset: outputs drop immediately, training is discarded
    i_pc_if = 32'h4c; i_mem_valid = 1'b1; i_pc_mem = 32'h4c; i_inst_mem = BEQ;
    i_actual_taken = 1'b1; i_actual_target = 32'h30;
    i_pred_taken_mem = 1'b1; i_pred_target_mem = 32'h20;
    #1;
    check32("pre_reset_pred", 100, {31'd0, o_pred_taken}, 32'd1);
    check32("pre_reset_mis", 100, {31'd0, o_mispredict}, 32'd1);
    rst = 1'b1;
    #1;
    check32("in_reset_pred", 101, {31'd0, o_pred_taken}, 32'd0);
    check32("in_reset_mis", 101, {31'd0, o_mispredict}, 32'd0);
    check32("in_reset_br", 101, o_br_count, 32'd0);
    check32("in_reset_miss", 101, o_miss_count, 32'd0);
    @(posedge clk);
    #1 i_mem_valid = 1'b0;
    rst = 1'b0;
    #2;
    check32("post_reset_pred", 102, {31'd0, o_pred_taken}, 32'd0);
    check32("post_reset_tgt", 102, o_pred_target, 32'h50);
    check32("post_reset_br", 102, o_br_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
